// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring radix-2 divider, signed/unsigned, with flush
module div_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_acc;   // partial remainder magnitude
   logic [WIDTH-1:0] quo_acc;   // dividend shifts out / quotient shifts in; raw dividend on /0
   logic [WIDTH-1:0] dvs_mag;   // divisor magnitude
   logic             neg_q, neg_r, dz;

   logic [WIDTH:0]   rem_shift, rem_trial;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             a_neg, b_neg, b_zero, last_step;

   assign a_neg     = is_signed & dividend[WIDTH-1];
   assign b_neg     = is_signed & divisor[WIDTH-1];
   assign a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
   assign b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
   assign b_zero    = (divisor == '0);
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // Shift the next dividend bit into the partial remainder and try a subtract;
   // a set top bit of the trial means the divisor did not fit.
   assign rem_shift = {rem_acc, quo_acc[WIDTH-1]};
   assign rem_trial = rem_shift - {1'b0, dvs_mag};

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; flush wins over everything, including a same-cycle start
   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (start) state_nx = b_zero ? FIX : CALC;
            CALC:    if (last_step) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Datapath: operand capture, one restoring step per CALC cycle, result fix-up in FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         rem_acc   <= '0;
         quo_acc   <= '0;
         dvs_mag   <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         dz        <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!flush) begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     cnt     <= '0;
                     rem_acc <= '0;
                     quo_acc <= b_zero ? dividend : a_mag;
                     dvs_mag <= b_mag;
                     neg_q   <= a_neg ^ b_neg;
                     neg_r   <= a_neg;
                     dz      <= b_zero;
                  end
               end
               CALC: begin
                  cnt <= cnt + 1'b1;
                  if (!rem_trial[WIDTH]) begin
                     rem_acc <= rem_trial[WIDTH-1:0];
                     quo_acc <= {quo_acc[WIDTH-2:0], 1'b1};
                  end else begin
                     rem_acc <= rem_shift[WIDTH-1:0];
                     quo_acc <= {quo_acc[WIDTH-2:0], 1'b0};
                  end
               end
               FIX: begin
                  done     <= 1'b1;
                  div_zero <= dz;
                  if (dz) begin
                     quotient  <= '1;
                     remainder <= quo_acc;
                  end else begin
                     quotient  <= neg_q ? (~quo_acc + 1'b1) : quo_acc;
                     remainder <= neg_r ? (~rem_acc + 1'b1) : rem_acc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed self-checking bench for div_iter at WIDTH=32
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int n_cmp = 0;
   int n_err = 0;

   div_iter #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one start, count cycles from the start edge until done, check results.
   task automatic run_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] eq, input logic [31:0] er, input logic edz);
      int n;
      n = 0;
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, lat);
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
      check({tag, "_dz"}, div_zero, edz);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   // Count done pulses over a fixed window.
   task automatic count_done(input int cycles, output int dones);
      dones = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
   endtask

   initial begin
      int dones;
      int n;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0; flush = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_q", quotient, 32'h0);
      check("rst_r", remainder, 32'h0);
      check("rst_dz", div_zero, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_div("u7_2",   1'b0, 32'd7,        32'd2,        33, 32'd3,        32'd1,        1'b0);
      run_div("sm7_2",  1'b1, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      run_div("s7_m2",  1'b1, 32'd7,        32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1,        1'b0);
      run_div("s_ovf",  1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h0,        1'b0);
      run_div("u_min",  1'b0, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h80000000, 1'b0);
      run_div("u_big",  1'b0, 32'hFFFFFFFF, 32'd10,       33, 32'h19999999, 32'd5,        1'b0);
      run_div("s_zero", 1'b1, 32'hFFFFFFF0, 32'h0,        1,  32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1);
      run_div("u_dz",   1'b0, 32'h12345678, 32'h0,        1,  32'hFFFFFFFF, 32'h12345678, 1'b1);
      run_div("u9_3",   1'b0, 32'd9,        32'd3,        33, 32'd3,        32'd0,        1'b0);

      // Flush at CALC step 10: no done, outputs held from 9/3
      is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("fl_busy", busy, 1'b0);
      count_done(40, dones);
      check("fl_nodone", dones, 0);
      check("fl_q", quotient, 32'd3);
      check("fl_r", remainder, 32'd0);
      check("fl_dz", div_zero, 1'b0);

      // Flush and start together in IDLE: start ignored
      flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      check("flst_busy", busy, 1'b0);

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

      // Start while busy is ignored
      is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      repeat (5) begin @(posedge clk); #1; n++; end
      dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      while (!done && n < 100) begin @(posedge clk); #1; n++; end
      check("ign_lat", n, 33);
      check("ign_q", quotient, 32'd10);
      check("ign_r", remainder, 32'd0);
      count_done(40, dones);
      check("ign_nodone", dones, 0);

      // Reset mid-CALC clears outputs asynchronously, discards the operation
      dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_q", quotient, 32'h0);
      check("arst_r", remainder, 32'h0);
      check("arst_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_done(40, dones);
      check("arst_nodone", dones, 0);
      check("arst_dz", div_zero, 1'b0);

      run_div("post_rst", 1'b0, 32'd7, 32'd2, 33, 32'd3, 32'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
